// File: rtl/pipe_ctrl_stager.sv
// pipe_ctrl_stager: carries decoder wb/m/ex bundles through ID/EX, EX/MEM, MEM/WB; hazard, flush, forward control (PIPE_FORWARD_EN enables forwarding).
// Latency: one edge per stage, WB strobes 3 edges after ID; forward/hazard/pc_src are combinational.
// Backpressure: none accepted; a stall holds PC and IF/ID and injects a bubble into ID/EX.
module pipe_ctrl_stager #(
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            id_wb,
   input  logic [2:0]            id_m,
   input  logic [ALU_OP_W:0]     id_ex,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  mem_zero,
   output logic                  ex_alu_src,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   output logic                  wb_reg_write,
   output logic                  wb_memtoreg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  pc_src
);

   // Bit positions inside the decoder bundles.
   localparam int WB_RW  = 1;
   localparam int WB_MTR = 0;
   localparam int M_BR   = 2;
   localparam int M_WR   = 1;
   localparam int M_RD   = 0;

   // ID/EX control register
   logic [1:0]            idex_wb;
   logic [2:0]            idex_m;
   logic [ALU_OP_W:0]     idex_ex;
   logic [REG_ADDR_W-1:0] idex_rd;

   // EX/MEM control register (ex field is consumed in EX and not carried on)
   logic [1:0]            exmem_wb;
   logic [2:0]            exmem_m;
   logic [REG_ADDR_W-1:0] exmem_rd;

   // MEM/WB control register
   logic [1:0]            memwb_wb;
   logic [REG_ADDR_W-1:0] memwb_rd;

   logic hazard;
   logic stall;
   logic flush;

   // A source depends on a stage only if that stage really writes a non-x0 register.
   function automatic logic src_match(input logic [REG_ADDR_W-1:0] rs,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  rw);
      return (rs == rd) && (rd != '0) && rw;
   endfunction

   // Branch resolves in MEM; a taken branch flushes and outranks any stall.
   always_comb begin
      flush = exmem_m[M_BR] & mem_zero;
      stall = hazard & ~flush;
   end

`ifdef PIPE_FORWARD_EN
   logic [REG_ADDR_W-1:0] idex_rs1;
   logic [REG_ADDR_W-1:0] idex_rs2;

   // Only a load in EX must stall its consumer: its data appears in MEM/WB, one cycle late.
   always_comb begin
      hazard = idex_m[M_RD] &
               (src_match(id_rs1, idex_rd, idex_wb[WB_RW]) |
                src_match(id_rs2, idex_rd, idex_wb[WB_RW]));
   end

   // EX/MEM holds the younger result, so it takes priority over MEM/WB.
   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (src_match(idex_rs1, exmem_rd, exmem_wb[WB_RW]))
         forward_a = 2'b10;
      else if (src_match(idex_rs1, memwb_rd, memwb_wb[WB_RW]))
         forward_a = 2'b01;
      if (src_match(idex_rs2, exmem_rd, exmem_wb[WB_RW]))
         forward_b = 2'b10;
      else if (src_match(idex_rs2, memwb_rd, memwb_wb[WB_RW]))
         forward_b = 2'b01;
   end

   // Source indices are only needed by the forwarding comparators; bubbles carry zeros.
   always_ff @(posedge clk) begin
      if (!rst_n || stall || flush) begin
         idex_rs1 <= '0;
         idex_rs2 <= '0;
      end else begin
         idex_rs1 <= id_rs1;
         idex_rs2 <= id_rs2;
      end
   end
`else
   // Without forwarding a consumer waits until its producer reaches the write-through WB stage.
   always_comb begin
      hazard = src_match(id_rs1, idex_rd,  idex_wb[WB_RW])  |
               src_match(id_rs2, idex_rd,  idex_wb[WB_RW])  |
               src_match(id_rs1, exmem_rd, exmem_wb[WB_RW]) |
               src_match(id_rs2, exmem_rd, exmem_wb[WB_RW]);
   end

   assign forward_a = 2'b00;
   assign forward_b = 2'b00;
`endif

   // ID/EX: take the decoded bundle, or a bubble on stall or flush.
   always_ff @(posedge clk) begin
      if (!rst_n || stall || flush) begin
         idex_wb <= '0;
         idex_m  <= '0;
         idex_ex <= '0;
         idex_rd <= '0;
      end else begin
         idex_wb <= id_wb;
         idex_m  <= id_m;
         idex_ex <= id_ex;
         idex_rd <= id_rd;
      end
   end

   // EX/MEM: advance from ID/EX; a flush squashes the instruction behind the branch.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         exmem_wb <= '0;
         exmem_m  <= '0;
         exmem_rd <= '0;
      end else begin
         exmem_wb <= idex_wb;
         exmem_m  <= idex_m;
         exmem_rd <= idex_rd;
      end
   end

   // MEM/WB: always advances; the branch itself retires normally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         memwb_wb <= '0;
         memwb_rd <= '0;
      end else begin
         memwb_wb <= exmem_wb;
         memwb_rd <= exmem_rd;
      end
   end

   // Stage strobes come straight from the stage registers.
   always_comb begin
      ex_alu_src   = idex_ex[ALU_OP_W];
      ex_alu_op    = idex_ex[ALU_OP_W-1:0];
      mem_rd_en    = exmem_m[M_RD];
      mem_wr_en    = exmem_m[M_WR];
      wb_reg_write = memwb_wb[WB_RW];
      wb_memtoreg  = memwb_wb[WB_MTR];
      wb_rd        = memwb_rd;
      pc_write     = ~stall;
      if_id_write  = ~stall;
      if_id_flush  = flush;
      pc_src       = flush;
   end

endmodule

// File: tb/tb_pipe_ctrl_stager.sv
// tb_pipe_ctrl_stager: directed vector table plus randomized instruction stream against a stage-array model.
// Each cycle: drive inputs, compare at negedge, advance the model after the rising edge.
// The random driver holds ID on predicted stalls and feeds a NOP after predicted flushes.
module tb_pipe_ctrl_stager;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] id_wb;
   logic [2:0] id_m;
   logic [2:0] id_ex;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       mem_zero;
   logic       ex_alu_src;
   logic [1:0] ex_alu_op;
   logic       mem_rd_en, mem_wr_en, wb_reg_write, wb_memtoreg;
   logic [4:0] wb_rd;
   logic [1:0] forward_a, forward_b;
   logic       pc_write, if_id_write, if_id_flush, pc_src;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl_stager #(.REG_ADDR_W(5), .ALU_OP_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_zero(mem_zero),
      .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .mem_rd_en(mem_rd_en),
      .mem_wr_en(mem_wr_en), .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg),
      .wb_rd(wb_rd), .forward_a(forward_a), .forward_b(forward_b),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .pc_src(pc_src)
   );

   // One instruction's control view
   typedef struct {
      logic       rw, mtr, br, mw, mr, src;
      logic [1:0] op;
      logic [4:0] rs1, rs2, rd;
   } ins_t;

   // Directed vector: inputs plus hand-derived expected outputs (before the edge)
   typedef struct {
      ins_t       in;
      logic       z;
      logic [1:0] e_op;
      logic       e_mrd, e_rw;
      logic [4:0] e_wrd;
      logic       e_pcw;
      logic [1:0] e_fa, e_fb;
      logic       e_src;
   } vec_t;

   // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB
   ins_t pipe[3];

   function automatic ins_t mk(logic rw, logic mtr, logic br, logic mw, logic mr, logic src,
                               logic [1:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
      ins_t i;
      i.rw = rw; i.mtr = mtr; i.br = br; i.mw = mw; i.mr = mr; i.src = src;
      i.op = op; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
      return i;
   endfunction

   function automatic ins_t nop_i();
      return mk(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
   endfunction
   function automatic ins_t r_i(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
      return mk(1, 0, 0, 0, 0, 0, 2'b10, rs1, rs2, rd);
   endfunction
   function automatic ins_t lw_i(logic [4:0] rs1, logic [4:0] rd);
      return mk(1, 1, 0, 0, 1, 1, 2'b00, rs1, 5'd0, rd);
   endfunction
   function automatic ins_t sw_i(logic [4:0] rs1, logic [4:0] rs2);
      return mk(0, 0, 0, 1, 0, 1, 2'b00, rs1, rs2, 5'd0);
   endfunction
   function automatic ins_t beq_i(logic [4:0] rs1, logic [4:0] rs2);
      return mk(0, 0, 1, 0, 0, 0, 2'b01, rs1, rs2, 5'd0);
   endfunction

   function automatic vec_t v(ins_t i, logic z, logic [1:0] op, logic mrd, logic rw, logic [4:0] wrd,
                              logic pcw, logic [1:0] fa, logic [1:0] fb, logic src);
      vec_t r;
      r.in = i; r.z = z; r.e_op = op; r.e_mrd = mrd; r.e_rw = rw; r.e_wrd = wrd;
      r.e_pcw = pcw; r.e_fa = fa; r.e_fb = fb; r.e_src = src;
      return r;
   endfunction

   // Does a producer write the register this source reads?
   function automatic bit hit(logic [4:0] rs, ins_t p);
      return (rs != 5'd0) && p.rw && (p.rd == rs);
   endfunction

   // Forward source by producer distance: 1 stage ahead -> 10, 2 stages ahead -> 01
   function automatic logic [1:0] fwd_sel(logic [4:0] rs);
`ifdef PIPE_FORWARD_EN
      for (int d = 1; d <= 2; d++)
         if (hit(rs, pipe[d])) return (d == 1) ? 2'b10 : 2'b01;
`endif
      return 2'b00 & {2{rs[0]}};
   endfunction

   function automatic bit m_stall(ins_t id);
`ifdef PIPE_FORWARD_EN
      return pipe[0].mr && (hit(id.rs1, pipe[0]) || hit(id.rs2, pipe[0]));
`else
      bit s = 0;
      for (int d = 0; d <= 1; d++)
         if (hit(id.rs1, pipe[d]) || hit(id.rs2, pipe[d])) s = 1;
      return s;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input ins_t i, input logic z);
      id_wb  = {i.rw, i.mtr};
      id_m   = {i.br, i.mw, i.mr};
      id_ex  = {i.src, i.op};
      id_rs1 = i.rs1;
      id_rs2 = i.rs2;
      id_rd  = i.rd;
      mem_zero = z;
   endtask

   task automatic check_model(input bit st, input bit fl);
      chk("ex_alu_src",   32'(ex_alu_src),   32'(pipe[0].src));
      chk("ex_alu_op",    32'(ex_alu_op),    32'(pipe[0].op));
      chk("mem_rd_en",    32'(mem_rd_en),    32'(pipe[1].mr));
      chk("mem_wr_en",    32'(mem_wr_en),    32'(pipe[1].mw));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(pipe[2].rw));
      chk("wb_memtoreg",  32'(wb_memtoreg),  32'(pipe[2].mtr));
      chk("wb_rd",        32'(wb_rd),        32'(pipe[2].rd));
      chk("forward_a",    32'(forward_a),    32'(fwd_sel(pipe[0].rs1)));
      chk("forward_b",    32'(forward_b),    32'(fwd_sel(pipe[0].rs2)));
      chk("pc_write",     32'(pc_write),     32'(!st));
      chk("if_id_write",  32'(if_id_write),  32'(!st));
      chk("if_id_flush",  32'(if_id_flush),  32'(fl));
      chk("pc_src",       32'(pc_src),       32'(fl));
   endtask

   task automatic check_row(input int idx, input vec_t r);
      chk($sformatf("row%0d_alu_op", idx), 32'(ex_alu_op), 32'(r.e_op));
      chk($sformatf("row%0d_mem_rd", idx), 32'(mem_rd_en), 32'(r.e_mrd));
      chk($sformatf("row%0d_wb_rw", idx), 32'(wb_reg_write), 32'(r.e_rw));
      chk($sformatf("row%0d_wb_rd", idx), 32'(wb_rd), 32'(r.e_wrd));
      chk($sformatf("row%0d_pc_write", idx), 32'(pc_write), 32'(r.e_pcw));
      chk($sformatf("row%0d_if_id_write", idx), 32'(if_id_write), 32'(r.e_pcw));
      chk($sformatf("row%0d_fwd_a", idx), 32'(forward_a), 32'(r.e_fa));
      chk($sformatf("row%0d_fwd_b", idx), 32'(forward_b), 32'(r.e_fb));
      chk($sformatf("row%0d_pc_src", idx), 32'(pc_src), 32'(r.e_src));
      chk($sformatf("row%0d_flush", idx), 32'(if_id_flush), 32'(r.e_src));
   endtask

   // One clock: drive, compare at negedge, advance the model after the edge.
   task automatic step(input ins_t id, input logic z, input logic rst, input int row_idx,
                       input vec_t row, output bit st_o, output bit fl_o);
      ins_t nxt[3];
      bit   st, fl;
      rst_n = rst;
      drive(id, z);
      @(negedge clk);
      fl = pipe[1].br && z;
      st = m_stall(id) && !fl;
      check_model(st, fl);
      if (row_idx >= 0) check_row(row_idx, row);
      if (!rst) begin
         for (int k = 0; k < 3; k++) nxt[k] = nop_i();
      end else begin
         nxt[2] = pipe[1];
         nxt[1] = fl ? nop_i() : pipe[0];
         nxt[0] = (st || fl) ? nop_i() : id;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) pipe[k] = nxt[k];
      st_o = st;
      fl_o = fl;
   endtask

   function automatic ins_t rand_ins();
      logic [4:0] a, b, d;
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
         0: return r_i(a, b, d);
         1: return lw_i(a, d);
         2: return sw_i(a, b);
         3: return beq_i(a, b);
         default: return nop_i();
      endcase
   endfunction

   initial begin
      vec_t vq[$];
      vec_t dummy;
      ins_t cur;
      bit   st, fl;

      // Reset held for 2 edges with a valid R bundle applied
      rst_n = 1'b0;
      drive(r_i(5'd1, 5'd2, 5'd5), 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ex_alu_src",   32'(ex_alu_src), 32'd0);
      chk("rst_ex_alu_op",    32'(ex_alu_op), 32'd0);
      chk("rst_mem_rd_en",    32'(mem_rd_en), 32'd0);
      chk("rst_mem_wr_en",    32'(mem_wr_en), 32'd0);
      chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
      chk("rst_wb_memtoreg",  32'(wb_memtoreg), 32'd0);
      chk("rst_wb_rd",        32'(wb_rd), 32'd0);
      chk("rst_forward_a",    32'(forward_a), 32'd0);
      chk("rst_forward_b",    32'(forward_b), 32'd0);
      chk("rst_if_id_flush",  32'(if_id_flush), 32'd0);
      chk("rst_pc_src",       32'(pc_src), 32'd0);
      chk("rst_pc_write",     32'(pc_write), 32'd1);
      chk("rst_if_id_write",  32'(if_id_write), 32'd1);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) pipe[k] = nop_i();

      // Directed table:    in                     z  op    mrd rw wrd   pcw fa     fb     src
      // R-type through the pipe
      vq.push_back(v(r_i(5'd1, 5'd2, 5'd5), 0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b10, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b00, 0, 1, 5'd5, 1, 2'b00, 2'b00, 0));
      // Taken branch overriding a concurrent load-use stall
      vq.push_back(v(beq_i(5'd0, 5'd0),    0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(lw_i(5'd0, 5'd3),     0, 2'b01, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd3, 5'd0, 5'd7), 1, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 1));
      vq.push_back(v(nop_i(),              1, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
`ifdef PIPE_FORWARD_EN
      // Load-use: one stall cycle, then MEM/WB forward
      vq.push_back(v(lw_i(5'd0, 5'd3),     0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd3, 5'd0, 5'd8), 0, 2'b00, 0, 0, 5'd0, 0, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd3, 5'd0, 5'd8), 0, 2'b00, 1, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b10, 0, 1, 5'd3, 1, 2'b01, 2'b00, 0));
      // EX-to-EX forward on operand B, no stall
      vq.push_back(v(r_i(5'd0, 5'd0, 5'd4), 0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd0, 5'd4, 5'd9), 0, 2'b10, 0, 1, 5'd8, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b10, 0, 0, 5'd0, 1, 2'b00, 2'b10, 0));
      // Same with rd = x0: never forwarded
      vq.push_back(v(r_i(5'd0, 5'd0, 5'd0), 0, 2'b00, 0, 1, 5'd4, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd0, 5'd0, 5'd10), 0, 2'b10, 0, 1, 5'd9, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b10, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b00, 0, 1, 5'd0, 1, 2'b00, 2'b00, 0));
`else
      // RAW without forwarding: two stall cycles, forwards stay 00
      vq.push_back(v(r_i(5'd0, 5'd0, 5'd6), 0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd6, 5'd0, 5'd8), 0, 2'b10, 0, 0, 5'd0, 0, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd6, 5'd0, 5'd8), 0, 2'b00, 0, 0, 5'd0, 0, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd6, 5'd0, 5'd8), 0, 2'b00, 0, 1, 5'd6, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b10, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      // x0 producer never stalls an x0 consumer
      vq.push_back(v(r_i(5'd0, 5'd0, 5'd0), 0, 2'b00, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(r_i(5'd0, 5'd0, 5'd11), 0, 2'b10, 0, 1, 5'd8, 1, 2'b00, 2'b00, 0));
      vq.push_back(v(nop_i(),              0, 2'b10, 0, 0, 5'd0, 1, 2'b00, 2'b00, 0));
`endif
      foreach (vq[i]) step(vq[i].in, vq[i].z, 1'b1, i, vq[i], st, fl);

      // Randomized stream against the model
      dummy = vq[0];
      cur = rand_ins();
      for (int n = 0; n < 3000; n++) begin
         logic rst_b;
         rst_b = ($urandom_range(0, 199) != 0);
         step(cur, 1'($urandom_range(0, 1)), rst_b, -1, dummy, st, fl);
         if (!rst_b)  cur = rand_ins();
         else if (fl) cur = nop_i();
         else if (!st) cur = rand_ins();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
